mux_scan_nx1: RTL and testbench
===============================

# mux_scan_nx1

Parametrised, registered N-channel multiplexer with a valid/ready output stage and an automatic round-robin scan mode. It generalises the combinational 4:1 selector in three ways: it handles any channel count and word width, it registers its output, and it can step through the channels by itself. It sits between a bank of parallel sources and a single serial consumer, for example a shared display or UART path, and applies backpressure through `out_ready`.

## Interface
- `N_CH`, 4, number of input channels (≥2)
- `WIDTH`, 1, bits per channel
- `DWELL`, 1, accepted samples per channel before scan advances (≥1)
- `SEL_W` (localparam), `$clog2(N_CH)`, channel index width

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in`  in  N_CH*WIDTH  packed channel data; channel k = `in[k*WIDTH +: WIDTH]`
- `sel`  in  SEL_W  channel index used in manual mode
- `mode`  in  1  0 = manual, 1 = scan
- `en`  in  1  sample request; no load while low
- `out`  out  WIDTH  registered selected data
- `out_valid`  out  1  `out` holds an unconsumed sample
- `out_ready`  in  1  consumer accepts `out` this cycle
- `cur_ch`  out  SEL_W  channel index of the sample in `out`
- `scan_wrap`  out  1  one-cycle pulse when scan index wraps from N_CH-1 to 0

## Operation
- Load condition: `load = en && (!out_valid || out_ready)`. On load, `out`, `cur_ch` and `out_valid=1` register the selected channel. With `out_valid && out_ready && !load`, `out_valid` clears and `out` holds its last value.
- FSM states:
  - S_MANUAL: selected channel = `sel`, sampled at the load edge. `sel ≥ N_CH` loads `out=0`, with `cur_ch=sel`.
  - S_SCAN: selected channel = internal `scan_ch`. `dwell_cnt` increments on each load. When a load occurs with `dwell_cnt==DWELL-1`, `dwell_cnt` returns to 0 and `scan_ch` goes to `scan_ch+1`. If `scan_ch` was N_CH-1 it goes to 0 instead and `scan_wrap` pulses on the next cycle.
- Transitions are evaluated each cycle on `mode`:
  - S_MANUAL→S_SCAN when `mode=1`. `scan_ch` and `dwell_cnt` are cleared, and the first scan load takes channel 0.
  - S_SCAN→S_MANUAL when `mode=0`. Scan state is frozen. It is cleared on re-entry to S_SCAN.
- A pending `out_valid` sample survives mode changes. It keeps the `cur_ch` it was loaded with.
- Stall: while `out_valid && !out_ready`, no load occurs, and `scan_ch` and `dwell_cnt` do not advance. Input changes during a stall are not captured.
- Reset mid-operation: all state returns to reset values immediately, regardless of `clk`. Any pending sample is discarded.

## Timing
- Reset values:
  - `out=0`, `out_valid=0`, `cur_ch=0`, `scan_wrap=0`
  - FSM = S_MANUAL, `scan_ch=0`, `dwell_cnt=0`
- Latency: 1 cycle, from the load edge to `out`/`out_valid`.
- Throughput: 1 sample/cycle when `en=1` and `out_ready=1` are held.
- Mode change: in cycle t, the `mode` value present at edge t selects the channel source for a load at edge t. The FSM updates at the same edge.
- `scan_wrap` is high for exactly one cycle, the cycle after the wrapping load.

## Configuration
- `MUX_SCAN_MASK_EN` defined:
  - Adds port `ch_mask  in  N_CH  1 = channel included in scan`.
  - Scan advance skips to the next set mask bit, searching upward from `scan_ch+1` modulo N_CH. `scan_wrap` pulses whenever the index passes through 0.
  - Entering S_SCAN starts at the lowest set bit.
  - If `ch_mask==0`, no loads occur in S_SCAN. `out_valid` drains normally.
  - Manual mode ignores the mask.
- Not defined: port absent, all N_CH channels are scanned.

## Test plan
- Manual mode, N_CH=4, WIDTH=8, `in={8'hDD,8'hCC,8'hBB,8'hAA}`, `sel=2`, `en=1`, `out_ready=1` → next cycle `out=8'hCC`, `cur_ch=2`, `out_valid=1`.
- Scan mode, DWELL=2, continuous `en`/`out_ready` → `out` sequence AA,AA,BB,BB,CC,CC,DD,DD,AA. `scan_wrap` is high for one cycle, the cycle after the second DD load.
- Backpressure: `out_ready=0` for 3 cycles in scan → `out`, `cur_ch` and `scan_ch` hold. On `out_ready=1` the next channel loads without skipping.
- Out-of-range select, N_CH=5 (SEL_W=3), manual mode, `sel=7` → `out=0`, `cur_ch=7`. Mode toggled to scan mid-run → next load is channel 0.
- Assert `rst` asynchronously mid-scan, between clock edges → `out_valid`, `out` and `scan_wrap` go to 0 immediately. After release, the first scan load is channel 0.
- With `MUX_SCAN_MASK_EN`, `ch_mask=4'b1010`, DWELL=1 → scan sequence ch1, ch3, ch1. `ch_mask=0` → `out_valid` stays 0.

Source files
------------

// File: rtl/mux_scan_nx1_if.sv
// mux_scan_nx1_if: channel bus between a bank of sources and the scanning mux.
//   in        packed channel data, channel k = in[k*WIDTH +: WIDTH]
//   sel       manual-mode channel index
//   mode      0 = manual, 1 = round-robin scan
//   en        sample request
//   out       registered selected sample
//   out_valid out holds an unconsumed sample
//   out_ready consumer accepts out this cycle
//   cur_ch    channel index of the sample in out
//   scan_wrap one-cycle pulse after a load that wraps the scan index
//   ch_mask   scan inclusion mask (only with MUX_SCAN_MASK_EN defined)
interface mux_scan_nx1_if #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned WIDTH = 1
);
   localparam int unsigned SEL_W = $clog2(N_CH);

   logic [N_CH*WIDTH-1:0] in;
   logic [SEL_W-1:0]      sel;
   logic                  mode;
   logic                  en;
   logic [WIDTH-1:0]      out;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_W-1:0]      cur_ch;
   logic                  scan_wrap;
`ifdef MUX_SCAN_MASK_EN
   logic [N_CH-1:0]       ch_mask;

   modport master (output in, sel, mode, en, out_ready, ch_mask,
                   input  out, out_valid, cur_ch, scan_wrap);
   modport slave  (input  in, sel, mode, en, out_ready, ch_mask,
                   output out, out_valid, cur_ch, scan_wrap);
`else
   modport master (output in, sel, mode, en, out_ready,
                   input  out, out_valid, cur_ch, scan_wrap);
   modport slave  (input  in, sel, mode, en, out_ready,
                   output out, out_valid, cur_ch, scan_wrap);
`endif
endinterface

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: registered N_CH:1 multiplexer with valid/ready output stage
// and an automatic round-robin scan mode.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mux_scan_nx1_if.slave (in, sel, mode, en, out_ready -> out,
//        out_valid, cur_ch, scan_wrap)
// Optional feature: define MUX_SCAN_MASK_EN to add bus.ch_mask, which
// restricts the scan to channels whose mask bit is set.
module mux_scan_nx1 #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DWELL = 1
) (
   input  logic           clk,
   input  logic           rst,
   mux_scan_nx1_if.slave  bus
);
   localparam int unsigned SEL_W = $clog2(N_CH);
   localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic {S_MANUAL = 1'b0, S_SCAN = 1'b1} state_t;

   state_t           state, state_next;
   logic [SEL_W-1:0] scan_ch, scan_ch_next;
   logic [CNT_W-1:0] dwell_cnt, dwell_next;
   logic [WIDTH-1:0] out_next;
   logic [SEL_W-1:0] cur_ch_next;
   logic             valid_next, wrap_next;

   logic [N_CH-1:0]  mask_c;
   logic             entering_c, load_c;
   logic [SEL_W-1:0] first_ch_c, eff_ch_c, adv_ch_c, src_ch_c;
   logic [CNT_W-1:0] eff_dwell_c;
   logic             adv_wrap_c;
   logic [WIDTH-1:0] src_word_c;

`ifdef MUX_SCAN_MASK_EN
   assign mask_c = bus.ch_mask;
`else
   assign mask_c = '1;
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_MANUAL;
      else     state <= state_next;
   end

   // next state follows mode every cycle
   always_comb begin
      state_next = S_MANUAL;
      if (bus.mode) state_next = S_SCAN;
   end

   // lowest included channel: start point when scan is (re)entered
   always_comb begin
      first_ch_c = '0;
      for (int i = int'(N_CH) - 1; i >= 0; i--)
         if (mask_c[i]) first_ch_c = SEL_W'(i);
   end

   // on entry the scan position is treated as already cleared, so the
   // load on the entry edge takes the first channel
   assign entering_c  = (state == S_MANUAL) && bus.mode;
   assign eff_ch_c    = entering_c ? first_ch_c : scan_ch;
   assign eff_dwell_c = entering_c ? '0 : dwell_cnt;

   // next included channel above eff_ch (mod N_CH); descending loop so the
   // nearest candidate wins; wrap flags a pass through index 0
   always_comb begin : adv_search
      int unsigned pos;
      int unsigned idx;
      adv_ch_c   = eff_ch_c;
      adv_wrap_c = 1'b0;
      for (int unsigned k = N_CH; k >= 1; k--) begin
         pos = int'(eff_ch_c) + k;
         idx = (pos >= N_CH) ? pos - N_CH : pos;
         if (mask_c[idx]) begin
            adv_ch_c   = SEL_W'(idx);
            adv_wrap_c = (pos >= N_CH);
         end
      end
   end

   // source is chosen by the live mode so a mode change applies on its own edge
   assign src_ch_c = bus.mode ? eff_ch_c : bus.sel;

   // out-of-range index selects zero
   always_comb begin
      src_word_c = '0;
      for (int unsigned k = 0; k < N_CH; k++)
         if (int'(src_ch_c) == k) src_word_c = bus.in[k*WIDTH +: WIDTH];
   end

   // an empty mask blocks scan loads
   assign load_c = bus.en && (!bus.out_valid || bus.out_ready) &&
                   !(bus.mode && (mask_c == '0));

   // output / datapath next values
   always_comb begin
      out_next     = bus.out;
      cur_ch_next  = bus.cur_ch;
      valid_next   = bus.out_valid;
      wrap_next    = 1'b0;
      scan_ch_next = scan_ch;
      dwell_next   = dwell_cnt;
      if (entering_c) begin
         scan_ch_next = first_ch_c;
         dwell_next   = '0;
      end
      if (load_c) begin
         out_next    = src_word_c;
         cur_ch_next = src_ch_c;
         valid_next  = 1'b1;
         if (bus.mode) begin
            if (eff_dwell_c == CNT_W'(DWELL - 1)) begin
               dwell_next   = '0;
               scan_ch_next = adv_ch_c;
               wrap_next    = adv_wrap_c;
            end else begin
               dwell_next   = eff_dwell_c + CNT_W'(1);
            end
         end
      end else if (bus.out_valid && bus.out_ready) begin
         valid_next = 1'b0;
      end
   end

   // output and scan registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
         bus.cur_ch    <= '0;
         bus.scan_wrap <= 1'b0;
         scan_ch       <= '0;
         dwell_cnt     <= '0;
      end else begin
         bus.out       <= out_next;
         bus.out_valid <= valid_next;
         bus.cur_ch    <= cur_ch_next;
         bus.scan_wrap <= wrap_next;
         scan_ch       <= scan_ch_next;
         dwell_cnt     <= dwell_next;
      end
   end
endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: directed bench for mux_scan_nx1.
//   dut_a: N_CH=4, WIDTH=8, DWELL=2 (manual, scan, backpressure, reset)
//   dut_b: N_CH=5, WIDTH=8, DWELL=1 (out-of-range select, scan entry)
//   dut_c: N_CH=4, WIDTH=8, DWELL=1 with MUX_SCAN_MASK_EN (mask scan)
module tb_mux_scan_nx1;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_scan_nx1_if #(.N_CH(4), .WIDTH(8)) bus_a ();
   mux_scan_nx1_if #(.N_CH(5), .WIDTH(8)) bus_b ();

   mux_scan_nx1 #(.N_CH(4), .WIDTH(8), .DWELL(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   mux_scan_nx1 #(.N_CH(5), .WIDTH(8), .DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

`ifdef MUX_SCAN_MASK_EN
   mux_scan_nx1_if #(.N_CH(4), .WIDTH(8)) bus_c ();
   mux_scan_nx1 #(.N_CH(4), .WIDTH(8), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));
`endif

   int n_checks = 0;
   int n_fail   = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [7:0] e_out, input logic e_valid,
                        input logic [1:0] e_ch, input logic e_wrap);
      cmp({tag, " out"},       32'(bus_a.out),       32'(e_out));
      cmp({tag, " out_valid"}, 32'(bus_a.out_valid), 32'(e_valid));
      cmp({tag, " cur_ch"},    32'(bus_a.cur_ch),    32'(e_ch));
      cmp({tag, " scan_wrap"}, 32'(bus_a.scan_wrap), 32'(e_wrap));
   endtask

   task automatic chk_b(input string tag, input logic [7:0] e_out, input logic e_valid,
                        input logic [2:0] e_ch, input logic e_wrap);
      cmp({tag, " out"},       32'(bus_b.out),       32'(e_out));
      cmp({tag, " out_valid"}, 32'(bus_b.out_valid), 32'(e_valid));
      cmp({tag, " cur_ch"},    32'(bus_b.cur_ch),    32'(e_ch));
      cmp({tag, " scan_wrap"}, 32'(bus_b.scan_wrap), 32'(e_wrap));
   endtask

   typedef struct {
      logic       mode;
      logic [1:0] sel;
      logic       en;
      logic       rdy;
      logic [7:0] e_out;
      logic       e_valid;
      logic [1:0] e_ch;
      logic       e_wrap;
   } vec_t;

   localparam int unsigned NV = 21;
   vec_t vecs [NV];

   initial begin
      // dut_a, in = {DD,CC,BB,AA}; each row is one clock edge
      vecs[0]  = '{1'b0, 2'd2, 1'b1, 1'b1, 8'hCC, 1'b1, 2'd2, 1'b0}; // manual sel=2
      vecs[1]  = '{1'b0, 2'd0, 1'b0, 1'b1, 8'hCC, 1'b0, 2'd2, 1'b0}; // drain, out holds
      vecs[2]  = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hAA, 1'b1, 2'd0, 1'b0}; // scan entry -> ch0
      vecs[3]  = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hAA, 1'b1, 2'd0, 1'b0};
      vecs[4]  = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hBB, 1'b1, 2'd1, 1'b0};
      vecs[5]  = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hBB, 1'b1, 2'd1, 1'b0};
      vecs[6]  = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hCC, 1'b1, 2'd2, 1'b0};
      vecs[7]  = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hCC, 1'b1, 2'd2, 1'b0};
      vecs[8]  = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hDD, 1'b1, 2'd3, 1'b0};
      vecs[9]  = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hDD, 1'b1, 2'd3, 1'b1}; // wrapping load
      vecs[10] = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hAA, 1'b1, 2'd0, 1'b0};
      vecs[11] = '{1'b1, 2'd0, 1'b1, 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0}; // stall x3
      vecs[12] = '{1'b1, 2'd3, 1'b1, 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0};
      vecs[13] = '{1'b1, 2'd1, 1'b1, 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0};
      vecs[14] = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hAA, 1'b1, 2'd0, 1'b0}; // second dwell of ch0
      vecs[15] = '{1'b1, 2'd0, 1'b1, 1'b1, 8'hBB, 1'b1, 2'd1, 1'b0}; // no skip
      vecs[16] = '{1'b0, 2'd3, 1'b1, 1'b1, 8'hDD, 1'b1, 2'd3, 1'b0}; // back to manual
      vecs[17] = '{1'b1, 2'd3, 1'b1, 1'b1, 8'hAA, 1'b1, 2'd0, 1'b0}; // re-entry clears scan
      vecs[18] = '{1'b1, 2'd3, 1'b1, 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0};
      vecs[19] = '{1'b0, 2'd2, 1'b0, 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0}; // pending survives mode change
      vecs[20] = '{1'b0, 2'd2, 1'b0, 1'b1, 8'hAA, 1'b0, 2'd0, 1'b0};

      rst = 1'b1;
      bus_a.in = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      bus_a.sel = '0; bus_a.mode = 1'b0; bus_a.en = 1'b0; bus_a.out_ready = 1'b0;
      bus_b.in = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      bus_b.sel = '0; bus_b.mode = 1'b0; bus_b.en = 1'b0; bus_b.out_ready = 1'b0;
`ifdef MUX_SCAN_MASK_EN
      bus_a.ch_mask = '1;
      bus_b.ch_mask = '1;
      bus_c.in = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      bus_c.sel = '0; bus_c.mode = 1'b0; bus_c.en = 1'b0; bus_c.out_ready = 1'b0;
      bus_c.ch_mask = 4'b1010;
`endif
      #2;
      chk_a("reset", 8'h00, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < int'(NV); i++) begin
         bus_a.mode      = vecs[i].mode;
         bus_a.sel       = vecs[i].sel;
         bus_a.en        = vecs[i].en;
         bus_a.out_ready = vecs[i].rdy;
         step();
         chk_a($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_valid, vecs[i].e_ch, vecs[i].e_wrap);
      end

      // asynchronous reset while scan_wrap is high
      bus_a.mode = 1'b1; bus_a.en = 1'b1; bus_a.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk_a("prewrap", 8'hDD, 1'b1, 2'd3, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk_a("async_rst", 8'h00, 1'b0, 2'd0, 1'b0);
      #2;
      rst = 1'b0;
      step();
      chk_a("post_rst", 8'hAA, 1'b1, 2'd0, 1'b0);
      bus_a.en = 1'b0;

      // dut_b: out-of-range manual select, then scan entry mid-run
      bus_b.en = 1'b1; bus_b.out_ready = 1'b1;
      bus_b.sel = 3'd7; step(); chk_b("b_sel7", 8'h00, 1'b1, 3'd7, 1'b0);
      bus_b.sel = 3'd5; step(); chk_b("b_sel5", 8'h00, 1'b1, 3'd5, 1'b0);
      bus_b.sel = 3'd4; step(); chk_b("b_sel4", 8'h55, 1'b1, 3'd4, 1'b0);
      bus_b.mode = 1'b1;
      step(); chk_b("b_scan0", 8'h11, 1'b1, 3'd0, 1'b0);
      step(); chk_b("b_scan1", 8'h22, 1'b1, 3'd1, 1'b0);
      step(); chk_b("b_scan2", 8'h33, 1'b1, 3'd2, 1'b0);
      step(); chk_b("b_scan3", 8'h44, 1'b1, 3'd3, 1'b0);
      step(); chk_b("b_scan4", 8'h55, 1'b1, 3'd4, 1'b1);
      step(); chk_b("b_scan5", 8'h11, 1'b1, 3'd0, 1'b0);
      bus_b.en = 1'b0;

`ifdef MUX_SCAN_MASK_EN
      // dut_c: masked scan ch1, ch3, ch1, then empty mask drains
      bus_c.mode = 1'b1; bus_c.en = 1'b1; bus_c.out_ready = 1'b1;
      step();
      cmp("c_m0 out", 32'(bus_c.out), 32'(8'hBB));
      cmp("c_m0 cur_ch", 32'(bus_c.cur_ch), 32'd1);
      step();
      cmp("c_m1 out", 32'(bus_c.out), 32'(8'hDD));
      cmp("c_m1 cur_ch", 32'(bus_c.cur_ch), 32'd3);
      cmp("c_m1 scan_wrap", 32'(bus_c.scan_wrap), 32'd1);
      step();
      cmp("c_m2 out", 32'(bus_c.out), 32'(8'hBB));
      cmp("c_m2 cur_ch", 32'(bus_c.cur_ch), 32'd1);
      cmp("c_m2 scan_wrap", 32'(bus_c.scan_wrap), 32'd0);
      bus_c.ch_mask = 4'b0000;
      step();
      cmp("c_empty0 out_valid", 32'(bus_c.out_valid), 32'd0);
      step();
      cmp("c_empty1 out_valid", 32'(bus_c.out_valid), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
